// File: rtl/epidemic_router_node.sv
// rtl/epidemic_router_node.sv - flooding mesh router node with per-port FIFOs, broadcast slot and seen-ID filter
module epidemic_router_node #(
    parameter int         DW      = 16,
    parameter int         IDW     = 4,
    parameter int         TW      = 3,
    parameter int         FD      = 4,
    parameter int         SEEN    = 8,
    parameter logic [3:0] PORT_EN = 4'hF
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          i_valid_l,
    input  logic          i_valid_r,
    input  logic          i_valid_t,
    input  logic          i_valid_b,
    input  logic          i_valid_p,
    input  logic [DW-1:0] i_data_l,
    input  logic [DW-1:0] i_data_r,
    input  logic [DW-1:0] i_data_t,
    input  logic [DW-1:0] i_data_b,
    input  logic [DW-1:0] i_data_p,
    output logic          o_ready_l,
    output logic          o_ready_r,
    output logic          o_ready_t,
    output logic          o_ready_b,
    output logic          o_ready_p,
    output logic          o_valid_l,
    output logic          o_valid_r,
    output logic          o_valid_t,
    output logic          o_valid_b,
    output logic          o_valid_p,
    output logic [DW-1:0] o_data_l,
    output logic [DW-1:0] o_data_r,
    output logic [DW-1:0] o_data_t,
    output logic [DW-1:0] o_data_b,
    output logic [DW-1:0] o_data_p,
    input  logic          i_ready_l,
    input  logic          i_ready_r,
    input  logic          i_ready_t,
    input  logic          i_ready_b,
    input  logic          i_ready_p,
    output logic [7:0]    o_dup_cnt
);
    localparam int         NP     = 5;
    localparam int         FAW    = (FD > 1) ? $clog2(FD) : 1;
    localparam int         SAW    = (SEEN > 1) ? $clog2(SEEN) : 1;
    localparam int         PW     = DW - IDW - TW;
    localparam logic [2:0] PORT_P = 3'd4;

    // Port index order everywhere: 0=l, 1=r, 2=t, 3=b, 4=p
    logic [NP-1:0]   w_en;
    logic [NP-1:0]   w_in_valid;
    logic [NP-1:0]   w_out_ready;
    logic [DW-1:0]   w_in_data [NP];
    logic [NP-1:0]   w_full;
    logic [NP-1:0]   w_empty;
    logic [NP-1:0]   w_in_ready;
    logic [NP-1:0]   w_push;

    logic [DW-1:0]   r_mem [NP][FD];
    logic [FAW:0]    r_wp [NP];
    logic [FAW:0]    r_rp [NP];

    logic [DW-1:0]   r_slot_data;
    logic [NP-1:0]   r_slot_mask;
    logic [IDW-1:0]  r_seen_id [SEEN];
    logic [SEEN-1:0] r_seen_v;
    logic [SAW-1:0]  r_seen_wp;
    logic [2:0]      r_rr;
    logic [7:0]      r_dup;

    logic [3:0]      w_scan;
    logic            w_gnt_vld;
    logic [2:0]      w_gnt_idx;
    logic            w_pop;
    logic [DW-1:0]   w_head;
    logic [IDW-1:0]  w_head_id;
    logic [TW-1:0]   w_head_ttl;
    logic            w_hit;
    logic [3:0]      w_mesh_mask;
    logic [NP-1:0]   w_new_mask;
    logic [TW-1:0]   w_slot_ttl;
    logic [DW-1:0]   w_mesh_data;
    logic [NP-1:0]   w_out_valid;
    logic [NP-1:0]   w_accept;

    assign w_en        = {1'b1, PORT_EN};
    assign w_in_valid  = {i_valid_p, i_valid_b, i_valid_t, i_valid_r, i_valid_l};
    assign w_out_ready = {i_ready_p, i_ready_b, i_ready_t, i_ready_r, i_ready_l};
    assign w_in_data[0] = i_data_l;
    assign w_in_data[1] = i_data_r;
    assign w_in_data[2] = i_data_t;
    assign w_in_data[3] = i_data_b;
    assign w_in_data[4] = i_data_p;

    // Full compares the wrap bit; a pop in the same cycle never frees a slot for a push
    for (genvar g = 0; g < NP; g++) begin : g_fifo_flags
        assign w_empty[g]    = (r_wp[g] == r_rp[g]);
        assign w_full[g]     = (r_wp[g][FAW] != r_rp[g][FAW]) &&
                               (r_wp[g][FAW-1:0] == r_rp[g][FAW-1:0]);
        assign w_in_ready[g] = w_en[g] & ~w_full[g];
        assign w_push[g]     = w_in_valid[g] & w_in_ready[g];
    end

    // Round-robin scan starting at r_rr, which points one past the last grant
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = 3'd0;
        w_scan    = 4'd0;
        for (int k = 0; k < NP; k++) begin
            w_scan = {1'b0, r_rr} + 4'(k);
            if (w_scan >= 4'(NP)) begin
                w_scan = w_scan - 4'(NP);
            end
            if (!w_gnt_vld && !w_empty[w_scan[2:0]]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = w_scan[2:0];
            end
        end
    end

    assign w_pop      = w_gnt_vld && (r_slot_mask == '0);
    assign w_head     = r_mem[w_gnt_idx][r_rp[w_gnt_idx][FAW-1:0]];
    assign w_head_id  = w_head[DW-1 -: IDW];
    assign w_head_ttl = w_head[DW-IDW-1 -: TW];

    always_comb begin
        w_hit = 1'b0;
        for (int s = 0; s < SEEN; s++) begin
            if (r_seen_v[s] && (r_seen_id[s] == w_head_id)) begin
                w_hit = 1'b1;
            end
        end
    end

    // Expired flits still reach the local PE, unless the PE itself injected them
    assign w_mesh_mask = (w_head_ttl != '0) ? (PORT_EN & ~(4'b0001 << w_gnt_idx)) : 4'b0000;
    assign w_new_mask  = {(w_gnt_idx != PORT_P), w_mesh_mask};

    assign w_slot_ttl  = r_slot_data[DW-IDW-1 -: TW];
    assign w_mesh_data = {r_slot_data[DW-1 -: IDW], w_slot_ttl - TW'(1), r_slot_data[PW-1:0]};
    assign w_out_valid = r_slot_mask & w_en & {NP{rstn}};
    assign w_accept    = w_out_valid & w_out_ready;

    assign o_ready_l = rstn & w_in_ready[0];
    assign o_ready_r = rstn & w_in_ready[1];
    assign o_ready_t = rstn & w_in_ready[2];
    assign o_ready_b = rstn & w_in_ready[3];
    assign o_ready_p = rstn & w_in_ready[4];
    assign o_valid_l = w_out_valid[0];
    assign o_valid_r = w_out_valid[1];
    assign o_valid_t = w_out_valid[2];
    assign o_valid_b = w_out_valid[3];
    assign o_valid_p = w_out_valid[4];
    assign o_data_l  = rstn ? w_mesh_data : '0;
    assign o_data_r  = rstn ? w_mesh_data : '0;
    assign o_data_t  = rstn ? w_mesh_data : '0;
    assign o_data_b  = rstn ? w_mesh_data : '0;
    assign o_data_p  = rstn ? r_slot_data : '0;
    assign o_dup_cnt = r_dup;

    // Storage arrays carry no reset; their validity is tracked by pointers and r_seen_v
    always_ff @(posedge clk) begin
        for (int k = 0; k < NP; k++) begin
            if (rstn && w_push[k]) begin
                r_mem[k][r_wp[k][FAW-1:0]] <= w_in_data[k];
            end
        end
        if (rstn && w_pop && !w_hit) begin
            r_seen_id[r_seen_wp] <= w_head_id;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int k = 0; k < NP; k++) begin
                r_wp[k] <= '0;
                r_rp[k] <= '0;
            end
            r_slot_data <= '0;
            r_slot_mask <= '0;
            r_seen_v    <= '0;
            r_seen_wp   <= '0;
            r_rr        <= 3'd0;
            r_dup       <= 8'd0;
        end else begin
            for (int k = 0; k < NP; k++) begin
                if (w_push[k]) begin
                    r_wp[k] <= r_wp[k] + (FAW+1)'(1);
                end
            end
            if (w_pop) begin
                r_rp[w_gnt_idx] <= r_rp[w_gnt_idx] + (FAW+1)'(1);
                r_rr            <= (w_gnt_idx == PORT_P) ? 3'd0 : w_gnt_idx + 3'd1;
                if (w_hit) begin
                    if (r_dup != 8'hFF) begin
                        r_dup <= r_dup + 8'd1;
                    end
                end else begin
                    r_seen_v[r_seen_wp] <= 1'b1;
                    r_seen_wp           <= r_seen_wp + SAW'(1);
                    r_slot_data         <= w_head;
                    r_slot_mask         <= w_new_mask;
                end
            end else begin
                r_slot_mask <= r_slot_mask & ~w_accept;
            end
        end
    end
endmodule

// File: tb/tb_epidemic_router_node.sv
// tb/tb_epidemic_router_node.sv - scoreboard bench for epidemic_router_node (interior node A, edge node B)
module tb_epidemic_router_node;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic [4:0]  iv_a = '0, ir_a = '1, ov_a, or_a;
    logic [4:0]  iv_b = '0, ir_b = '1, ov_b, or_b;
    logic [15:0] id_a [5];
    logic [15:0] id_b [5];
    logic [15:0] od_a [5];
    logic [15:0] od_b [5];
    logic [7:0]  dup_a, dup_b;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_q [10][$];
    logic [9:0]  prev_stall = '0;
    logic [15:0] prev_data [10];
    logic        m_v, m_r;
    logic [15:0] m_d, m_e;

    epidemic_router_node #(.PORT_EN(4'hF)) u_a (
        .clk(clk), .rstn(rstn),
        .i_valid_l(iv_a[0]), .i_valid_r(iv_a[1]), .i_valid_t(iv_a[2]), .i_valid_b(iv_a[3]), .i_valid_p(iv_a[4]),
        .i_data_l(id_a[0]), .i_data_r(id_a[1]), .i_data_t(id_a[2]), .i_data_b(id_a[3]), .i_data_p(id_a[4]),
        .o_ready_l(or_a[0]), .o_ready_r(or_a[1]), .o_ready_t(or_a[2]), .o_ready_b(or_a[3]), .o_ready_p(or_a[4]),
        .o_valid_l(ov_a[0]), .o_valid_r(ov_a[1]), .o_valid_t(ov_a[2]), .o_valid_b(ov_a[3]), .o_valid_p(ov_a[4]),
        .o_data_l(od_a[0]), .o_data_r(od_a[1]), .o_data_t(od_a[2]), .o_data_b(od_a[3]), .o_data_p(od_a[4]),
        .i_ready_l(ir_a[0]), .i_ready_r(ir_a[1]), .i_ready_t(ir_a[2]), .i_ready_b(ir_a[3]), .i_ready_p(ir_a[4]),
        .o_dup_cnt(dup_a)
    );

    epidemic_router_node #(.PORT_EN(4'b0011)) u_b (
        .clk(clk), .rstn(rstn),
        .i_valid_l(iv_b[0]), .i_valid_r(iv_b[1]), .i_valid_t(iv_b[2]), .i_valid_b(iv_b[3]), .i_valid_p(iv_b[4]),
        .i_data_l(id_b[0]), .i_data_r(id_b[1]), .i_data_t(id_b[2]), .i_data_b(id_b[3]), .i_data_p(id_b[4]),
        .o_ready_l(or_b[0]), .o_ready_r(or_b[1]), .o_ready_t(or_b[2]), .o_ready_b(or_b[3]), .o_ready_p(or_b[4]),
        .o_valid_l(ov_b[0]), .o_valid_r(ov_b[1]), .o_valid_t(ov_b[2]), .o_valid_b(ov_b[3]), .o_valid_p(ov_b[4]),
        .o_data_l(od_b[0]), .o_data_r(od_b[1]), .o_data_t(od_b[2]), .o_data_b(od_b[3]), .o_data_p(od_b[4]),
        .i_ready_l(ir_b[0]), .i_ready_r(ir_b[1]), .i_ready_t(ir_b[2]), .i_ready_b(ir_b[3]), .i_ready_p(ir_b[4]),
        .o_dup_cnt(dup_b)
    );

    function automatic logic [15:0] mk(input int id, input int ttl, input int pl);
        return {4'(id), 3'(ttl), 9'(pl)};
    endfunction

    function automatic logic [15:0] dec(input logic [15:0] f);
        return {f[15:12], f[11:9] - 3'd1, f[8:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Scoreboard side: mesh queues receive ttl-1, the local queue receives the flit unchanged
    task automatic expect_mask(input int dut, input logic [15:0] f, input logic [4:0] mask);
        for (int k = 0; k < 5; k++) begin
            if (mask[k]) exp_q[dut*5+k].push_back((k == 4) ? f : dec(f));
        end
    endtask

    task automatic send(input int dut, input int port, input logic [15:0] f, input logic [4:0] mask);
        int  n;
        bit  got;
        expect_mask(dut, f, mask);
        @(posedge clk); #1;
        if (dut == 0) begin iv_a[port] = 1'b1; id_a[port] = f; end
        else          begin iv_b[port] = 1'b1; id_b[port] = f; end
        n = 0;
        got = 1'b0;
        while (!got && n < 50) begin
            @(negedge clk);
            if ((dut == 0) ? or_a[port] : or_b[port]) got = 1'b1;
            else n++;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL send_timeout dut %0d port %0d: ready stayed 0, required 1", dut, port);
        end
        @(posedge clk); #1;
        if (dut == 0) iv_a[port] = 1'b0;
        else          iv_b[port] = 1'b0;
    endtask

    // Monitor: every accepted egress flit is popped and compared; stalled outputs must hold
    always @(negedge clk) begin
        if (rstn) begin
            for (int k = 0; k < 10; k++) begin
                if (k < 5) begin m_v = ov_a[k]; m_r = ir_a[k]; m_d = od_a[k]; end
                else       begin m_v = ov_b[k-5]; m_r = ir_b[k-5]; m_d = od_b[k-5]; end
                if (prev_stall[k]) begin
                    checks++;
                    if (!m_v || m_d !== prev_data[k]) begin
                        errors++;
                        $display("FAIL hold q%0d: valid=%0b data=%h, required valid=1 data=%h", k, m_v, m_d, prev_data[k]);
                    end
                end
                if (m_v && m_r) begin
                    checks++;
                    if (exp_q[k].size() == 0) begin
                        errors++;
                        $display("FAIL unexpected q%0d: data=%h, required no output", k, m_d);
                    end else begin
                        m_e = exp_q[k].pop_front();
                        if (m_d !== m_e) begin
                            errors++;
                            $display("FAIL data q%0d: got %h expected %h", k, m_d, m_e);
                        end
                    end
                end
                prev_stall[k] = m_v && !m_r;
                prev_data[k]  = m_d;
            end
        end
    end

    initial begin
        for (int k = 0; k < 5; k++) begin
            id_a[k] = 16'hFFFF;
            id_b[k] = 16'hFFFF;
        end
        // Reset held two cycles with every ingress valid asserted
        rstn = 1'b0;
        iv_a = '1;
        iv_b = '1;
        @(posedge clk);
        @(negedge clk);
        chk("reset_valid_a", 32'(ov_a), 32'h0);
        chk("reset_valid_b", 32'(ov_b), 32'h0);
        chk("reset_ready_a", 32'(or_a), 32'h0);
        chk("reset_dup_a", 32'(dup_a), 32'h0);
        chk("reset_data_a_p", 32'(od_a[4]), 32'h0);
        @(posedge clk); #1;
        rstn = 1'b1;
        iv_a = '0;
        iv_b = '0;
        @(negedge clk);
        chk("post_reset_ready_a", 32'(or_a), 32'h1F);
        chk("post_reset_ready_b", 32'(or_b), 32'h13);
        chk("post_reset_valid_a", 32'(ov_a), 32'h0);

        // Flood from l on the interior node, with latency check
        send(0, 0, mk(5, 3, 9'h0AB), 5'b11110);
        @(negedge clk);
        chk("latency_n1_valid_r", 32'(ov_a[1]), 32'h0);
        @(negedge clk);
        chk("latency_n2_valid", 32'(ov_a), 32'h1E);
        repeat (3) @(posedge clk);

        // Duplicate id5 on t is dropped and counted
        send(0, 2, mk(5, 1, 9'h055), 5'b00000);
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("dup_count_1", 32'(dup_a), 32'h1);

        // Eight fresh IDs push id5 out of the seen table
        send(0, 0, mk(1, 1, 9'h101), 5'b11110);
        send(0, 0, mk(2, 1, 9'h102), 5'b11110);
        send(0, 0, mk(3, 1, 9'h103), 5'b11110);
        send(0, 0, mk(4, 1, 9'h104), 5'b11110);
        send(0, 0, mk(6, 1, 9'h106), 5'b11110);
        send(0, 0, mk(7, 1, 9'h107), 5'b11110);
        send(0, 0, mk(8, 1, 9'h108), 5'b11110);
        send(0, 0, mk(9, 1, 9'h109), 5'b11110);
        send(0, 2, mk(5, 2, 9'h1C5), 5'b11011);
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("dup_after_wrap", 32'(dup_a), 32'h1);

        // TTL=0: from r only p receives; from p nothing at all and no dup count
        send(0, 1, mk(10, 0, 9'h0A0), 5'b10000);
        send(0, 4, mk(11, 0, 9'h0B0), 5'b00000);
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("ttl0_no_dup", 32'(dup_a), 32'h1);

        // Backpressure on t: slot holds, second flit waits in FIFO l
        @(posedge clk); #1;
        ir_a[2] = 1'b0;
        send(0, 0, mk(12, 3, 9'h0C5), 5'b11110);
        send(0, 0, mk(13, 3, 9'h0D7), 5'b11110);
        repeat (10) @(negedge clk);
        chk("bp_no_new_pop_r", 32'(ov_a[1]), 32'h0);
        chk("bp_t_held_valid", 32'(ov_a[2]), 32'h1);
        @(posedge clk); #1;
        ir_a[2] = 1'b1;
        repeat (10) @(posedge clk);

        // Fill FIFO l behind a stuck slot
        #1;
        ir_a[2] = 1'b0;
        send(0, 0, mk(14, 1, 9'h0E0), 5'b11110);
        send(0, 0, mk(15, 1, 9'h0F0), 5'b11110);
        send(0, 0, mk(0, 1, 9'h000), 5'b11110);
        send(0, 0, mk(1, 1, 9'h111), 5'b11110);
        send(0, 0, mk(2, 1, 9'h122), 5'b11110);
        @(negedge clk);
        chk("fifo_full_ready_l", 32'(or_a[0]), 32'h0);
        chk("fifo_full_ready_r", 32'(or_a[1]), 32'h1);
        @(posedge clk); #1;
        ir_a[2] = 1'b1;
        repeat (30) @(posedge clk);

        // Edge node: simultaneous heads on l, r, p must be served l, r, p
        #1;
        expect_mask(1, mk(1, 2, 9'h011), 5'b10010);
        expect_mask(1, mk(2, 2, 9'h022), 5'b10001);
        expect_mask(1, mk(3, 2, 9'h033), 5'b00011);
        id_b[0] = mk(1, 2, 9'h011);
        id_b[1] = mk(2, 2, 9'h022);
        id_b[4] = mk(3, 2, 9'h033);
        iv_b = 5'b10011;
        @(posedge clk); #1;
        iv_b = '0;
        repeat (10) @(posedge clk);
        send(1, 0, mk(4, 3, 9'h044), 5'b10010);
        // Disabled port t: valid is ignored, ready stays low
        @(posedge clk); #1;
        id_b[2] = mk(6, 3, 9'h066);
        iv_b[2] = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("edge_ready_tb", 32'({or_b[3], or_b[2]}), 32'h0);
        @(posedge clk); #1;
        iv_b[2] = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("edge_dup_b", 32'(dup_b), 32'h0);

        for (int k = 0; k < 10; k++) begin
            checks++;
            if (exp_q[k].size() != 0) begin
                errors++;
                $display("FAIL drained q%0d: %0d flits still expected, required 0", k, exp_q[k].size());
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
